uart_rx: RTL

UART receiver, the receive-side counterpart of the existing uart_tx path. It consumes the shared 16x oversampling tick from uart_baudrate_gen and deserialises the asynchronous line (board uart_txd_in) into parallel words. It reports framing and parity errors per word and sits beside uart_tx in top, sharing the same baudrate generator instance.

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receive-side result bundle of uart_rx: parallel word plus per-word status.
// The receiver drives it through the master modport; consumers use slave.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic [DBIT-1:0] rx_data;
  logic            rx_done_tick;
  logic            frame_err;
  logic            parity_err;

  modport master (
    output rx_data,
    output rx_done_tick,
    output frame_err,
    output parity_err
  );

  modport slave (
    input rx_data,
    input rx_done_tick,
    input frame_err,
    input parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver on the shared 16x s_tick: start-bit mid-sampling, LSB-first
// data, optional parity, configurable stop length, per-word error flags.
module uart_rx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     s_tick,
  input  logic     rx,
  uart_rx_if.master bus
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  // Stop counting needs more than 4 bits once 1.5/2 stop bits are selected.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          PAR_ON = (PARITY_EN != 0);
  localparam logic          PAR_OD = (PARITY_ODD != 0);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [2:0]      state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            p_q, p_d;
  logic            stop_q, stop_d;
  logic            pend_q, pend_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            done_q, done_d;
  logic            fe_q, fe_d;
  logic            pe_q, pe_d;
  logic            rx_sync;

  assign rx_sync = sync2_q;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    stop_d  = stop_q;
    pend_d  = 1'b0;
    data_d  = data_q;
    done_d  = 1'b0;
    fe_d    = fe_q;
    pe_d    = pe_q;

    // Outputs are registered one clk after the stop sample; b is stable then
    // because only DATA modifies it.
    if (pend_q) begin
      data_d = b_q;
      fe_d   = ~stop_q;
      pe_d   = PAR_ON & (^b_q ^ p_q ^ PAR_OD);
      done_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_sync) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_sync) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            if (DBIT > 1) b_d = {rx_sync, b_q[DBIT-1:1]};
            else          b_d = DBIT'(rx_sync);
            if (n_q == N_LAST) state_d = PAR_ON ? ST_PARITY : ST_STOP;
            else               n_d = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            p_d     = rx_sync;
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            stop_d  = rx_sync;
            pend_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      stop_q  <= 1'b1;
      pend_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      stop_q  <= stop_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      done_q  <= done_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
    end
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = fe_q;
  assign bus.parity_err   = pe_q;

endmodule
